// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stage controller.
// The stall watchdog is built only when PIPE_STALL_WDOG_EN is defined.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DRAIN = 2'd1,
    TAKE       = 2'd2
  } irq_state_e;

  localparam int STAGE_PC = 0;

  localparam int DEF_NUM_STAGES       = 5;
  localparam int DEF_REDIRECT_DEPTH   = 3;
  localparam int DEF_REDIRECT_BUBBLES = 1;
  localparam int DEF_WDOG_W           = 8;
  localparam int DEF_WDOG_LIMIT       = 200;

  localparam int BUBBLE_CNT_W = 3;

endpackage

// File: rtl/pipe_irq_sequencer.sv
// Interrupt-take handshake: waits for a drained, quiet pipe, then takes the
// interrupt for one cycle, which also acts as a redirect.
//
//   state      | meaning
//   IDLE       | no interrupt pending
//   WAIT_DRAIN | request seen, waiting for no stalls, no redirect, no bubbles
//   TAKE       | interrupt taken this cycle (ack + internal redirect)
module pipe_irq_sequencer
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic irq_req,
  input  logic redirect,
  input  logic any_stall,
  input  logic bubble_busy,
  output logic irq_ack,
  output logic irq_redirect
);

  irq_state_e state, state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (irq_req) state_next = WAIT_DRAIN;
      end
      WAIT_DRAIN: begin
        // A request withdrawn while waiting is dropped without an ack.
        if (!irq_req)
          state_next = IDLE;
        else if (!any_stall && !redirect && !bubble_busy)
          state_next = TAKE;
      end
      TAKE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    irq_ack      = (state == TAKE);
    irq_redirect = (state == TAKE);
  end

endmodule

// File: rtl/pipeline_stage_controller.sv
// Per-stage enable/clear generation from stall and flush requests, with a
// redirect bubble tail, interrupt take sequencing and an optional stall
// watchdog (PIPE_STALL_WDOG_EN).
module pipeline_stage_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES       = DEF_NUM_STAGES,
  parameter int REDIRECT_DEPTH   = DEF_REDIRECT_DEPTH,
  parameter int REDIRECT_BUBBLES = DEF_REDIRECT_BUBBLES,
  parameter int WDOG_W           = DEF_WDOG_W,
  parameter int WDOG_LIMIT       = DEF_WDOG_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  input  logic                  redirect,
  input  logic                  irq_req,
  output logic                  irq_ack,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_clr,
  output logic [WDOG_W-1:0]     stall_cycles,
  output logic                  wdog_timeout
);

  localparam logic [NUM_STAGES-1:0] CLR_RESET = {{(NUM_STAGES-1){1'b1}}, 1'b0};

  logic [NUM_STAGES-1:0]   hold;
  logic [NUM_STAGES-1:0]   clr;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;
  logic                    bubble_busy;
  logic                    irq_redirect;
  logic                    redir_eff;
  logic                    any_stall;
  logic                    flush_pc_unused;

  assign flush_pc_unused = flush_req[STAGE_PC];
  assign any_stall       = |stall_req;
  assign bubble_busy     = (bubble_cnt != '0);
  assign redir_eff       = redirect | irq_redirect;

  // A stall anywhere downstream holds every register upstream of it.
  always_comb begin
    hold = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      for (int j = i; j < NUM_STAGES; j++) begin
        if (stall_req[j]) hold[i] = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      clr[i] = (redir_eff && (i <= REDIRECT_DEPTH)) ||
               (!hold[i] && (flush_req[i] || hold[i-1] ||
                             ((i == 1) && bubble_busy)));
    end
  end

  assign stage_en  = reset_n ? ~hold : '0;
  assign stage_clr = reset_n ? clr   : CLR_RESET;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bubble_cnt <= '0;
    else if (redir_eff)
      bubble_cnt <= BUBBLE_CNT_W'(REDIRECT_BUBBLES);
    else if (bubble_busy)
      bubble_cnt <= bubble_cnt - 1'b1;
  end

  pipe_irq_sequencer u_irq_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq_req      (irq_req),
    .redirect     (redirect),
    .any_stall    (any_stall),
    .bubble_busy  (bubble_busy),
    .irq_ack      (irq_ack),
    .irq_redirect (irq_redirect)
  );

`ifdef PIPE_STALL_WDOG_EN
  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] stall_cnt;
  logic [WDOG_W-1:0] stall_cnt_next;
  logic              timeout_q;

  always_comb begin
    if (stage_en[NUM_STAGES-1])
      stall_cnt_next = '0;
    else if (stall_cnt == CNT_MAX)
      stall_cnt_next = stall_cnt;
    else
      stall_cnt_next = stall_cnt + 1'b1;
  end

  // The flag rises on the same edge the count reaches the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      if (stall_cnt_next == WDOG_W'(WDOG_LIMIT)) timeout_q <= 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign wdog_timeout = timeout_q;
`else
  logic wdog_limit_unused;
  assign wdog_limit_unused = (WDOG_W'(WDOG_LIMIT) == '0);
  assign stall_cycles      = '0;
  assign wdog_timeout      = 1'b0;
`endif

endmodule
